// File: rtl/irq_pending_scheduler_pkg.sv
// irq_pending_scheduler_pkg
// Shared constants, FSM state type and helper functions for the pending-request
// scheduler that feeds the 16-line priority-encoded index output stage.
//   N_REQ     : number of request lines
//   IDX_W     : width of the presented index
//   CNT_W     : width of the saturating coalesce counter
//   NONE_CODE : index code driven while nothing is presented
package irq_pending_scheduler_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned CNT_W = 8;

    localparam logic [IDX_W-1:0] NONE_CODE = 8'hF0;

    typedef enum logic {
        EMPTY,
        PRESENT
    } state_e;

    // One-hot decode of an index onto the request lines; out-of-range codes give 0.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            r[i] = (idx == IDX_W'(i));
        end
        return r;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pending_pick.sv
// pending_pick
// Combinational highest-set-bit finder.
//   vec : input vector to search
//   idx : index of the highest set bit of vec (0 when vec is all zero)
//   any : vec has at least one bit set
module pending_pick #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < int'(N); i++) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/irq_pending_scheduler.sv
// irq_pending_scheduler
// Captures request pulses into a sticky pending vector and presents the
// highest-numbered pending request as an index behind a valid/ready handshake.
// A pending bit is cleared only when its index is accepted; a request that lands
// on an already-pending bit is counted as coalesced.
//   clk          : clock, all state on rising edge
//   rst_n        : synchronous active-low reset
//   req_in       : request lines, a high bit at an edge sets the pending bit
//   flush        : synchronous clear of pending, output stage and counter
//   out_valid    : out_idx holds a valid request index
//   out_ready    : downstream accepts out_idx on out_valid && out_ready
//   out_idx      : presented index, NONE_CODE while out_valid is low
//   pending      : registered pending vector (includes the presented bit)
//   coalesce_cnt : saturating count of cycles with at least one coalesced request
module irq_pending_scheduler
    import irq_pending_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pending,
    output logic [CNT_W-1:0] coalesce_cnt
);

    if ((N_REQ > (32'd1 << IDX_W)) || (32'(NONE_CODE) < N_REQ)) begin : g_bad_params
        $error("irq_pending_scheduler: index width or NONE_CODE cannot cover N_REQ");
    end

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             acc;
    logic [N_REQ-1:0] ack_mask;
    logic [N_REQ-1:0] cand_vec;
    logic [IDX_W-1:0] cand;
    logic             cand_any;
    logic             hit;

    assign acc      = valid_q && out_ready;
    assign ack_mask = acc ? onehot(idx_q) : '0;
    // Candidates come from registered state only; this cycle's req_in never competes.
    assign cand_vec = pending_q & ~ack_mask;
    assign hit      = |(req_in & cand_vec);

    pending_pick #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_pick (
        .vec (cand_vec),
        .idx (cand),
        .any (cand_any)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        // Set wins over the acknowledge clear.
        pending_d = cand_vec | req_in;
        cnt_d     = hit ? sat_inc(cnt_q) : cnt_q;

        unique case (state_q)
            EMPTY: begin
                if (cand_any) begin
                    state_d = PRESENT;
                    valid_d = 1'b1;
                    idx_d   = cand;
                end
            end
            PRESENT: begin
                // No preemption: the presented index holds until accepted.
                if (out_ready) begin
                    if (cand_any) begin
                        valid_d = 1'b1;
                        idx_d   = cand;
                    end else begin
                        state_d = EMPTY;
                        valid_d = 1'b0;
                        idx_d   = NONE_CODE;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                valid_d = 1'b0;
                idx_d   = NONE_CODE;
            end
        endcase

        if (flush) begin
            state_d   = EMPTY;
            valid_d   = 1'b0;
            idx_d     = NONE_CODE;
            pending_d = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            valid_q   <= 1'b0;
            idx_q     <= NONE_CODE;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_idx      = idx_q;
    assign pending      = pending_q;
    assign coalesce_cnt = cnt_q;

endmodule

// File: tb/tb_irq_pending_scheduler.sv
// tb_irq_pending_scheduler
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of the pending set, presented index and coalesce count.
module tb_irq_pending_scheduler;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_idx;
    logic [15:0] pending;
    logic [7:0]  coalesce_cnt;

    int unsigned checks;
    int unsigned failures;

    // Reference model state
    bit m_pend[16];
    int m_idx;   // presented index, -1 when nothing is presented
    int m_cnt;

    irq_pending_scheduler u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .pending      (pending),
        .coalesce_cnt (coalesce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_idx = -1;
        m_cnt = 0;
    endtask

    // Advance the model across one clock edge for the given inputs.
    task automatic model_step(input logic [15:0] req, input logic ready, input logic fl);
        bit acc;
        bit remain[16];
        bit hit;
        int cand;
        acc  = (m_idx >= 0) && ready;
        cand = -1;
        hit  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            remain[i] = m_pend[i] && !(acc && (i == m_idx));
            if (remain[i]) cand = i;
            if (remain[i] && req[i]) hit = 1'b1;
        end
        if (fl) begin
            model_reset();
        end else begin
            for (int i = 0; i < 16; i++) m_pend[i] = remain[i] || req[i];
            if (hit && m_cnt < 255) m_cnt++;
            if (m_idx < 0 || ready) m_idx = cand;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [15:0] exp_p;
        for (int i = 0; i < 16; i++) exp_p[i] = m_pend[i];
        check_eq({tag, ".valid"}, 32'(out_valid), (m_idx >= 0) ? 1 : 0);
        check_eq({tag, ".idx"}, 32'(out_idx), (m_idx >= 0) ? m_idx : 32'hF0);
        check_eq({tag, ".pending"}, 32'(pending), 32'(exp_p));
        check_eq({tag, ".cnt"}, 32'(coalesce_cnt), m_cnt);
    endtask

    task automatic drive(input logic [15:0] req, input logic ready, input logic fl,
                         input string tag);
        req_in    = req;
        out_ready = ready;
        flush     = fl;
        model_step(req, ready, fl);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            req_in    = 16'($urandom);
            flush     = c[0];
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        model_reset();
        rst_n = 1'b1;
        compare_all("reset");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_in    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // 1. Reset then idle
        apply_reset(3);
        for (int c = 0; c < 5; c++) drive(16'h0000, 1'b0, 1'b0, "idle");
        check_eq("idle_none", 32'(out_idx), 32'hF0);
        check_eq("idle_cnt", 32'(coalesce_cnt), 0);

        // 2. Single request
        drive(16'h0020, 1'b1, 1'b0, "single");
        check_eq("single_e0_valid", 32'(out_valid), 0);
        drive(16'h0000, 1'b1, 1'b0, "single");
        check_eq("single_idx", 32'(out_idx), 5);
        check_eq("single_valid", 32'(out_valid), 1);
        drive(16'h0000, 1'b1, 1'b0, "single");
        check_eq("single_drain_valid", 32'(out_valid), 0);
        check_eq("single_drain_pend", 32'(pending), 0);

        // 3. Ordering, back-to-back
        drive(16'h8101, 1'b1, 1'b0, "order");
        drive(16'h0000, 1'b1, 1'b0, "order");
        check_eq("order_15", 32'(out_idx), 15);
        drive(16'h0000, 1'b1, 1'b0, "order");
        check_eq("order_8", 32'(out_idx), 8);
        drive(16'h0000, 1'b1, 1'b0, "order");
        check_eq("order_0", 32'(out_idx), 0);
        drive(16'h0000, 1'b1, 1'b0, "order");
        check_eq("order_none", 32'(out_idx), 32'hF0);

        // 4. Stability and coalesce
        drive(16'h0000, 1'b0, 1'b1, "flush4");
        drive(16'h0008, 1'b0, 1'b0, "hold");
        drive(16'h0000, 1'b0, 1'b0, "hold");
        for (int c = 0; c < 3; c++) drive(16'h4008, 1'b0, 1'b0, "hold");
        check_eq("hold_idx", 32'(out_idx), 3);
        check_eq("hold_cnt", 32'(coalesce_cnt), 3);
        drive(16'h0000, 1'b1, 1'b0, "hold");
        check_eq("hold_next14", 32'(out_idx), 14);
        drive(16'h0000, 1'b1, 1'b0, "hold");

        // 5. Set wins on acknowledge
        drive(16'h0000, 1'b1, 1'b1, "flush5");
        drive(16'h0080, 1'b1, 1'b0, "setwin");
        drive(16'h0000, 1'b1, 1'b0, "setwin");
        check_eq("setwin_first", 32'(out_idx), 7);
        drive(16'h0080, 1'b1, 1'b0, "setwin");
        check_eq("setwin_bubble", 32'(out_valid), 0);
        check_eq("setwin_pend", 32'(pending), 32'h0080);
        drive(16'h0000, 1'b1, 1'b0, "setwin");
        check_eq("setwin_again", 32'(out_idx), 7);
        drive(16'h0000, 1'b1, 1'b0, "setwin");

        // 6. Flush mid-PRESENT, then saturation
        drive(16'h0c00, 1'b0, 1'b0, "flush6");
        drive(16'h0000, 1'b0, 1'b0, "flush6");
        drive(16'hFFFF, 1'b1, 1'b1, "flush6");
        check_eq("flush_pend", 32'(pending), 0);
        check_eq("flush_valid", 32'(out_valid), 0);
        check_eq("flush_idx", 32'(out_idx), 32'hF0);
        for (int c = 0; c < 300; c++) drive(16'h0001, 1'b0, 1'b0, "sat");
        check_eq("sat_cnt", 32'(coalesce_cnt), 255);

        // Randomized traffic
        drive(16'h0000, 1'b0, 1'b1, "rnd");
        for (int c = 0; c < 600; c++) begin
            drive(16'($urandom & $urandom & $urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) == 0), "rnd");
        end

        // Reset overrides busy traffic
        drive(16'hA5A5, 1'b0, 1'b0, "pre_rst");
        drive(16'h0000, 1'b0, 1'b0, "pre_rst");
        apply_reset(1);
        check_eq("rst_pend", 32'(pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
